// File: rtl/gift_keysched_unit.sv
// rtl/gift_keysched_unit.sv - GIFT-64/GIFT-128 round-key scheduler
//
// Purpose: holds the 128-bit GIFT key state and round constant and presents
// one round key per cycle in encryption (1..ROUNDS) or decryption
// (ROUNDS..1) order. Decryption first seeks forward to the last round key.
//
// Ports:
//   inClk         clock, rising edge
//   inRst         synchronous active-high reset
//   inLoad        start a new schedule from inKey (direction from inDir)
//   inKey         128-bit master key, words k7..k0, k0 = [15:0]
//   inDir         0 = encryption order, 1 = decryption order
//   inStep        advance to the next round key while outValid=1
//   outRoundKey   {k5,k4,k1,k0} for GIFT-128, {k1,k0} for GIFT-64
//   outRoundConst 6-bit round constant of the current round
//   outRound      1-based current round index
//   outKey        full 128-bit key state
//   outValid      round key / constant / index valid (READY)
//   outBusy       forward seek in progress (SEEK)
//   outLast       current round is final in the loaded direction
module gift_keysched_unit #(
    parameter int STATE_W = 128
) (
    input  logic                 inClk,
    input  logic                 inRst,
    input  logic                 inLoad,
    input  logic [127:0]         inKey,
    input  logic                 inDir,
    input  logic                 inStep,
    output logic [STATE_W/2-1:0] outRoundKey,
    output logic [5:0]           outRoundConst,
    output logic [5:0]           outRound,
    output logic [127:0]         outKey,
    output logic                 outValid,
    output logic                 outBusy,
    output logic                 outLast
);

    localparam int ROUNDS = (STATE_W == 64) ? 28 : 40;
    localparam int RK_W   = STATE_W / 2;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS);
    localparam logic [5:0] SEEK_END   = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state, state_n;
    logic [127:0] key, key_n;
    logic [5:0]   rc, rc_n;
    logic [5:0]   round, round_n;
    logic         dir, dir_n;
    logic [RK_W-1:0] rk;

    // Forward update: k7 <- k1 >>> 2, k6 <- k0 >>> 12, remaining words shift down by two.
    function automatic logic [127:0] fwd_key(input logic [127:0] k);
        logic [15:0] k1;
        logic [15:0] k0;
        k1 = k[31:16];
        k0 = k[15:0];
        return {k1[1:0], k1[15:2], k0[11:0], k0[15:12], k[127:32]};
    endfunction

    // Inverse update undoes fwd_key exactly.
    function automatic logic [127:0] inv_key(input logic [127:0] k);
        logic [15:0] k7;
        logic [15:0] k6;
        k7 = k[127:112];
        k6 = k[111:96];
        return {k[95:0], k7[13:0], k7[15:14], k6[3:0], k6[15:4]};
    endfunction

    function automatic logic [5:0] fwd_rc(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [5:0] inv_rc(input logic [5:0] c);
        return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
    endfunction

    always_comb begin
        state_n = state;
        key_n   = key;
        rc_n    = rc;
        round_n = round;
        dir_n   = dir;
        if (inLoad) begin
            // Load overrides everything, including a concurrent step.
            key_n   = inKey;
            rc_n    = 6'h01;
            round_n = 6'd1;
            dir_n   = inDir;
            state_n = inDir ? SEEK : READY;
        end else begin
            case (state)
                SEEK: begin
                    key_n   = fwd_key(key);
                    rc_n    = fwd_rc(rc);
                    round_n = round + 6'd1;
                    if (round == SEEK_END) begin
                        state_n = READY;
                    end
                end
                READY: begin
                    if (inStep) begin
                        if (!dir) begin
                            if (round == LAST_ROUND) begin
                                state_n = DONE;
                            end else begin
                                key_n   = fwd_key(key);
                                rc_n    = fwd_rc(rc);
                                round_n = round + 6'd1;
                            end
                        end else begin
                            if (round == 6'd1) begin
                                state_n = DONE;
                            end else begin
                                key_n   = inv_key(key);
                                rc_n    = inv_rc(rc);
                                round_n = round - 6'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state <= IDLE;
            key   <= '0;
            rc    <= '0;
            round <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            key   <= key_n;
            rc    <= rc_n;
            round <= round_n;
            dir   <= dir_n;
        end
    end

    generate
        if (STATE_W == 64) begin : g_rk64
            assign rk = key[31:0];
        end else begin : g_rk128
            assign rk = {key[95:64], key[31:0]};
        end
    endgenerate

    assign outRoundKey   = rk;
    assign outRoundConst = rc;
    assign outRound      = round;
    assign outKey        = key;
    assign outValid      = (state == READY);
    assign outBusy       = (state == SEEK);
    assign outLast       = (state == READY) && (dir ? (round == 6'd1) : (round == LAST_ROUND));

endmodule

// File: doc/gift_keysched_unit.md
GIFT_KEYSCHED_UNIT -- requirements
Module: gift_keysched_unit

Interface
REQ-001 SHALL have parameter STATE_W, default 128, cipher state width; legal values 64 (GIFT-64, ROUNDS=28) and 128 (GIFT-128, ROUNDS=40).
REQ-002 SHALL derive localparams ROUNDS (28 or 40) and RK_W = STATE_W/2 (round-key width: 32 or 64).
REQ-003 inClk  input  1  single clock; all state updates on rising edge.
REQ-004 inRst  input  1  reset, synchronous, active-high.
REQ-005 inLoad  input  1  start a new schedule from inKey.
REQ-006 inKey  input  128  master key; 16-bit words k7..k0, k0 = bits [15:0].
REQ-007 inDir  input  1  sampled with inLoad; 0 = encryption order (round 1..ROUNDS), 1 = decryption order (round ROUNDS..1).
REQ-008 inStep  input  1  request advance to next round key; accepted only while outValid=1.
REQ-009 outRoundKey  output  RK_W  current round key: STATE_W=128: {k5,k4,k1,k0}; STATE_W=64: {k1,k0}.
REQ-010 outRoundConst  output  6  round constant of current round.
REQ-011 outRound  output  6  current round index, 1-based.
REQ-012 outKey  output  128  full current key state.
REQ-013 outValid  output  1  outRoundKey/outRoundConst/outRound are valid.
REQ-014 outBusy  output  1  seek in progress.
REQ-015 outLast  output  1  current round is the final round in the loaded direction.

Function
REQ-016 SHALL implement FSM states IDLE, SEEK, READY, DONE.
REQ-017 Forward update: k7..k0 <= (k1>>>2), (k0>>>12), k7, k6, k5, k4, k3, k2; constant c <= {c4,c3,c2,c1,c0, c5^c4^1}.
REQ-018 Inverse update: k7..k0 <= k5, k4, k3, k2, k1, k0, (k7<<<2), (k6<<<12); constant c <= {c0^c5^1, c5,c4,c3,c2,c1}.
REQ-019 inLoad, in any state, SHALL on that edge set key<=inKey, const<=6'h01, round<=1, latch inDir; inStep in the same cycle is ignored.
REQ-020 Load with inDir=0 -> READY; outValid=1 one cycle after the load edge.
REQ-021 Load with inDir=1 -> SEEK; outBusy=1, outValid=0; one forward update per cycle for exactly ROUNDS-1 cycles, round incrementing; then -> READY with round=ROUNDS; outValid rises ROUNDS cycles after the load edge.
REQ-022 READY, inStep=1, dir=0: round<ROUNDS -> forward update, round+1; round=ROUNDS -> DONE, key/const/round hold.
REQ-023 READY, inStep=1, dir=1: round>1 -> inverse update, round-1; round=1 -> DONE, key/const/round hold.
REQ-024 outLast = READY and (dir=0 ? round=ROUNDS : round=1).
REQ-025 inStep SHALL be ignored in IDLE, SEEK and DONE; DONE exits only via inLoad or inRst.
REQ-026 outValid=1 only in READY; outBusy=1 only in SEEK; step throughput one round key per cycle.
REQ-027 inKey bits are used in full regardless of STATE_W; only round-key extraction and ROUNDS depend on STATE_W.

Reset
REQ-028 inRst=1 SHALL, at the edge, force IDLE, key=0, const=0, round=0, outValid=0, outBusy=0, outLast=0; inRst has priority over inLoad and inStep.
REQ-029 inRst during SEEK SHALL abort the seek; no partial result is presented.

Verification
REQ-030 STATE_W=128, load inKey=128'h1, inDir=0 -> next cycle outValid=1, outRound=1, outRoundConst=6'h01, outRoundKey=64'h1; one inStep -> outKey=128'h0000_0010_0000_0000_0000_0000_0000_0000, outRoundConst=6'h03, outRound=2.
REQ-031 STATE_W=128, inDir=0, step continuously -> constants 01,03,07,0F,1F,3E,...; outLast at round 40 with const 6'h1A; next inStep -> DONE, outValid=0.
REQ-032 STATE_W=128, random key, inDir=1 -> outBusy high 39 cycles, outValid rises 40 cycles after load, outRound=40, outRoundConst=6'h1A, outKey equals forward-run round-40 key; 39 inSteps -> outKey=inKey, const 6'h01, outLast=1.
REQ-033 STATE_W=64, inDir=1 -> outValid after 28 cycles, outRound=28, outRoundConst=6'h0B, outRoundKey={k1,k0} of round-28 key.
REQ-034 inRst asserted at SEEK cycle 10 -> IDLE, all outputs zero next cycle; inLoad concurrent with inStep in READY -> load wins, outRound=1.
REQ-035 inStep asserted in IDLE, SEEK and DONE -> no change to outKey, outRound, outRoundConst.
